// File: rtl/mdom_scdb_hdr_pkg.sv
// Shared definitions for the SCDB header bundle: field layout, word counts,
// word indices and the serializer state type.
package mdom_scdb_hdr_pkg;

  localparam int HDR_BUNDLE_W = 111;

  localparam int EVT_LTC_LSB       = 0;
  localparam int EVT_LTC_W         = 49;
  localparam int START_ADDR_LSB    = 49;
  localparam int START_ADDR_W      = 11;
  localparam int STOP_ADDR_LSB     = 60;
  localparam int STOP_ADDR_W       = 11;
  localparam int TRIG_SRC_LSB      = 71;
  localparam int TRIG_SRC_W        = 2;
  localparam int CNST_RUN_BIT      = 73;
  localparam int PRE_CONF_LSB      = 74;
  localparam int PRE_CONF_W        = 5;
  localparam int SYNC_RDY_BIT      = 79;
  localparam int BSUM_LSB          = 80;
  localparam int BSUM_W            = 19;
  localparam int BSUM_LEN_SEL_LSB  = 99;
  localparam int BSUM_LEN_SEL_W    = 3;
  localparam int BSUM_VALID_BIT    = 102;
  localparam int LOCAL_COINC_BIT   = 103;
  localparam int PARTIAL_WFM_BIT   = 104;
  localparam int CONTINUED_WFM_BIT = 105;
  localparam int CHANNEL_IDX_LSB   = 106;
  localparam int CHANNEL_IDX_W     = 5;

  localparam int EVT_LTC_MSB      = EVT_LTC_LSB + EVT_LTC_W - 1;
  localparam int START_ADDR_MSB   = START_ADDR_LSB + START_ADDR_W - 1;
  localparam int STOP_ADDR_MSB    = STOP_ADDR_LSB + STOP_ADDR_W - 1;
  localparam int TRIG_SRC_MSB     = TRIG_SRC_LSB + TRIG_SRC_W - 1;
  localparam int PRE_CONF_MSB     = PRE_CONF_LSB + PRE_CONF_W - 1;
  localparam int BSUM_MSB         = BSUM_LSB + BSUM_W - 1;
  localparam int BSUM_LEN_SEL_MSB = BSUM_LEN_SEL_LSB + BSUM_LEN_SEL_W - 1;
  localparam int CHANNEL_IDX_MSB  = CHANNEL_IDX_LSB + CHANNEL_IDX_W - 1;

  localparam int HDR_WORDS_FULL   = 9;
  localparam int HDR_WORDS_NOBSUM = 7;

  localparam logic [3:0] W_IDX_HEAD    = 4'd0;
  localparam logic [3:0] W_IDX_CONF    = 4'd1;
  localparam logic [3:0] W_IDX_LTC_HI  = 4'd2;
  localparam logic [3:0] W_IDX_LTC_MID = 4'd3;
  localparam logic [3:0] W_IDX_LTC_LO  = 4'd4;
  localparam logic [3:0] W_IDX_START   = 4'd5;
  localparam logic [3:0] W_IDX_STOP    = 4'd6;
  localparam logic [3:0] W_IDX_BSUM_HI = 4'd7;
  localparam logic [3:0] W_IDX_BSUM_LO = 4'd8;

  localparam logic [3:0] DEFAULT_MARKER = 4'hE;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/mdom_scdb_hdr_bundle_fan_out.sv
// Combinational unpacker: splits a packed SCDB header bundle into its fields.
module mdom_scdb_hdr_bundle_fan_out
  import mdom_scdb_hdr_pkg::*;
(
  input  logic [HDR_BUNDLE_W-1:0]   bundle,
  output logic [EVT_LTC_W-1:0]      evt_ltc,
  output logic [START_ADDR_W-1:0]   start_addr,
  output logic [STOP_ADDR_W-1:0]    stop_addr,
  output logic [TRIG_SRC_W-1:0]     trig_src,
  output logic                      cnst_run,
  output logic [PRE_CONF_W-1:0]     pre_conf,
  output logic                      sync_rdy,
  output logic [BSUM_W-1:0]         bsum,
  output logic [BSUM_LEN_SEL_W-1:0] bsum_len_sel,
  output logic                      bsum_valid,
  output logic                      local_coinc,
  output logic                      partial_wfm,
  output logic                      continued_wfm,
  output logic [CHANNEL_IDX_W-1:0]  channel_idx
);

  assign evt_ltc       = bundle[EVT_LTC_MSB:EVT_LTC_LSB];
  assign start_addr    = bundle[START_ADDR_MSB:START_ADDR_LSB];
  assign stop_addr     = bundle[STOP_ADDR_MSB:STOP_ADDR_LSB];
  assign trig_src      = bundle[TRIG_SRC_MSB:TRIG_SRC_LSB];
  assign cnst_run      = bundle[CNST_RUN_BIT];
  assign pre_conf      = bundle[PRE_CONF_MSB:PRE_CONF_LSB];
  assign sync_rdy      = bundle[SYNC_RDY_BIT];
  assign bsum          = bundle[BSUM_MSB:BSUM_LSB];
  assign bsum_len_sel  = bundle[BSUM_LEN_SEL_MSB:BSUM_LEN_SEL_LSB];
  assign bsum_valid    = bundle[BSUM_VALID_BIT];
  assign local_coinc   = bundle[LOCAL_COINC_BIT];
  assign partial_wfm   = bundle[PARTIAL_WFM_BIT];
  assign continued_wfm = bundle[CONTINUED_WFM_BIT];
  assign channel_idx   = bundle[CHANNEL_IDX_MSB:CHANNEL_IDX_LSB];

endmodule

// File: rtl/mdom_scdb_hdr_serializer.sv
// Pops one header bundle from the header FIFO and streams it out as a fixed
// sequence of 16-bit readout words, flagging the final word with out_last.
module mdom_scdb_hdr_serializer
  import mdom_scdb_hdr_pkg::*;
#(
  parameter bit         SKIP_INVALID_BSUM = 1'b1,
  parameter logic [3:0] MARKER            = DEFAULT_MARKER
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [HDR_BUNDLE_W-1:0] hdr_bundle,
  input  logic                    hdr_valid,
  output logic                    hdr_rdy,
  output logic [15:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_rdy,
  output logic                    out_last,
  output logic [15:0]             hdr_cnt,
  output logic                    busy
);

  ser_state_e              state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [HDR_BUNDLE_W-1:0] bundle_q, bundle_d;
  logic [15:0]             hdr_cnt_q, hdr_cnt_d;

  logic [EVT_LTC_W-1:0]      f_evt_ltc;
  logic [START_ADDR_W-1:0]   f_start_addr;
  logic [STOP_ADDR_W-1:0]    f_stop_addr;
  logic [TRIG_SRC_W-1:0]     f_trig_src;
  logic                      f_cnst_run;
  logic [PRE_CONF_W-1:0]     f_pre_conf;
  logic                      f_sync_rdy;
  logic [BSUM_W-1:0]         f_bsum;
  logic [BSUM_LEN_SEL_W-1:0] f_bsum_len_sel;
  logic                      f_bsum_valid;
  logic                      f_local_coinc;
  logic                      f_partial_wfm;
  logic                      f_continued_wfm;
  logic [CHANNEL_IDX_W-1:0]  f_channel_idx;

  logic [15:0] word_sel;
  logic [3:0]  last_idx;
  logic        is_last;

  mdom_scdb_hdr_bundle_fan_out u_fan_out (
    .bundle        (bundle_q),
    .evt_ltc       (f_evt_ltc),
    .start_addr    (f_start_addr),
    .stop_addr     (f_stop_addr),
    .trig_src      (f_trig_src),
    .cnst_run      (f_cnst_run),
    .pre_conf      (f_pre_conf),
    .sync_rdy      (f_sync_rdy),
    .bsum          (f_bsum),
    .bsum_len_sel  (f_bsum_len_sel),
    .bsum_valid    (f_bsum_valid),
    .local_coinc   (f_local_coinc),
    .partial_wfm   (f_partial_wfm),
    .continued_wfm (f_continued_wfm),
    .channel_idx   (f_channel_idx)
  );

  // The header is shortened only on the latched bsum_valid, never the live input.
  assign last_idx = (SKIP_INVALID_BSUM && !f_bsum_valid) ? 4'(HDR_WORDS_NOBSUM - 1)
                                                         : 4'(HDR_WORDS_FULL - 1);
  assign is_last  = (idx_q == last_idx);

  always_comb begin
    word_sel = 16'h0000;
    case (idx_q)
      W_IDX_HEAD:    word_sel = {MARKER, f_channel_idx, f_trig_src, f_cnst_run, f_sync_rdy,
                                 f_local_coinc, f_partial_wfm, f_continued_wfm};
      W_IDX_CONF:    word_sel = {f_pre_conf, f_bsum_len_sel, f_bsum_valid, 6'b0, f_evt_ltc[48]};
      W_IDX_LTC_HI:  word_sel = f_evt_ltc[47:32];
      W_IDX_LTC_MID: word_sel = f_evt_ltc[31:16];
      W_IDX_LTC_LO:  word_sel = f_evt_ltc[15:0];
      W_IDX_START:   word_sel = {5'b0, f_start_addr};
      W_IDX_STOP:    word_sel = {5'b0, f_stop_addr};
      W_IDX_BSUM_HI: word_sel = {13'b0, f_bsum[18:16]};
      W_IDX_BSUM_LO: word_sel = f_bsum[15:0];
      default:       word_sel = 16'h0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bundle_d  = bundle_q;
    hdr_cnt_d = hdr_cnt_q;
    hdr_rdy   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        hdr_rdy = rst_n;
        if (hdr_valid) begin
          bundle_d = hdr_bundle;
          idx_d    = 4'd0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = word_sel;
        out_last  = is_last;
        if (out_rdy) begin
          if (is_last) begin
            idx_d     = 4'd0;
            state_d   = ST_IDLE;
            hdr_cnt_d = hdr_cnt_q + 16'd1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      bundle_q  <= '0;
      hdr_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bundle_q  <= bundle_d;
      hdr_cnt_q <= hdr_cnt_d;
    end
  end

  assign hdr_cnt = hdr_cnt_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mdom_scdb_hdr_serializer.sv
// Self-checking bench for mdom_scdb_hdr_serializer: table of header vectors
// plus reset, back-to-back, counter wrap and mid-header reset sequences.
module tb_mdom_scdb_hdr_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [110:0] hdr_bundle = '0;
  logic         hdr_valid = 1'b0;
  logic         out_rdy = 1'b1;

  logic         hdr_rdy, out_valid, out_last, busy;
  logic [15:0]  out_data, hdr_cnt;
  logic         hdr_rdy_b, out_valid_b, out_last_b, busy_b;
  logic [15:0]  out_data_b, hdr_cnt_b;

  int errors = 0;
  int checks = 0;

  logic [16:0] sbq_a[$];
  logic [16:0] sbq_b[$];
  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [16:0] held_a = '0, held_b = '0;
  logic [15:0] cap [0:8];
  int          cap_n = 0;
  logic [15:0] cnt_exp = 16'd0;
  logic [3:0]  rdy_pat = 4'b1111;
  int          phase = 0;

  typedef struct {
    logic [4:0]  chan;
    logic [1:0]  trig;
    logic [48:0] ltc;
    logic [10:0] start;
    logic [10:0] stop;
    logic [18:0] bsum;
    logic        bvalid;
    logic [2:0]  lensel;
    logic [4:0]  pre;
    logic [4:0]  flags;
    logic [3:0]  rdy;
    logic [15:0] exp_w0;
    logic [15:0] exp_w6;
    int          exp_len;
  } vec_t;

  vec_t vecs [0:4];

  mdom_scdb_hdr_serializer dut (
    .clk(clk), .rst_n(rst_n), .hdr_bundle(hdr_bundle), .hdr_valid(hdr_valid),
    .hdr_rdy(hdr_rdy), .out_data(out_data), .out_valid(out_valid), .out_rdy(out_rdy),
    .out_last(out_last), .hdr_cnt(hdr_cnt), .busy(busy)
  );

  mdom_scdb_hdr_serializer #(.SKIP_INVALID_BSUM(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .hdr_bundle(hdr_bundle), .hdr_valid(hdr_valid),
    .hdr_rdy(hdr_rdy_b), .out_data(out_data_b), .out_valid(out_valid_b), .out_rdy(out_rdy),
    .out_last(out_last_b), .hdr_cnt(hdr_cnt_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // flags = {cnst_run, sync_rdy, local_coinc, partial_wfm, continued_wfm}
  function automatic logic [110:0] pack_vec(input vec_t v);
    return {v.chan, v.flags[0], v.flags[1], v.flags[2], v.bvalid, v.lensel, v.bsum,
            v.flags[3], v.pre, v.flags[4], v.trig, v.stop, v.start, v.ltc};
  endfunction

  function automatic void model_words(input logic [110:0] b, input bit skip,
                                      output logic [8:0][15:0] w, output int n);
    w[0] = {4'hE, b[110:106], b[72:71], b[73], b[79], b[103], b[104], b[105]};
    w[1] = {b[78:74], b[101:99], b[102], 6'b0, b[48]};
    w[2] = b[47:32];
    w[3] = b[31:16];
    w[4] = b[15:0];
    w[5] = {5'b0, b[59:49]};
    w[6] = {5'b0, b[70:60]};
    w[7] = {13'b0, b[98:96]};
    w[8] = b[95:80];
    n = (skip && !b[102]) ? 7 : 9;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic monitor_step();
    logic [8:0][15:0] w;
    int n;
    logic [16:0] e;
    if (!rst_n) begin
      sbq_a.delete();
      sbq_b.delete();
      stall_a = 1'b0;
      stall_b = 1'b0;
      return;
    end
    if (hdr_valid && hdr_rdy) begin
      model_words(hdr_bundle, 1'b1, w, n);
      for (int i = 0; i < n; i++) sbq_a.push_back({(i == n - 1), w[i]});
      cap_n = 0;
    end
    if (hdr_valid && hdr_rdy_b) begin
      model_words(hdr_bundle, 1'b0, w, n);
      for (int i = 0; i < n; i++) sbq_b.push_back({(i == n - 1), w[i]});
    end
    if (stall_a) checkOutput("hold_a", {15'd0, out_valid, out_last, out_data}, {15'd0, 1'b1, held_a});
    if (stall_b) checkOutput("hold_b", {15'd0, out_valid_b, out_last_b, out_data_b}, {15'd0, 1'b1, held_b});
    if (out_valid && out_rdy) begin
      if (sbq_a.size() == 0) checkOutput("extra_word_a", {15'd0, out_last, out_data}, 32'hFFFF_FFFF);
      else begin
        e = sbq_a.pop_front();
        checkOutput("word_a", {15'd0, out_last, out_data}, {15'd0, e});
      end
      if (cap_n < 9) cap[cap_n] = out_data;
      cap_n++;
    end
    if (out_valid_b && out_rdy) begin
      if (sbq_b.size() == 0) checkOutput("extra_word_b", {15'd0, out_last_b, out_data_b}, 32'hFFFF_FFFF);
      else begin
        e = sbq_b.pop_front();
        checkOutput("word_b", {15'd0, out_last_b, out_data_b}, {15'd0, e});
      end
    end
    stall_a = out_valid && !out_rdy;
    held_a  = {out_last, out_data};
    stall_b = out_valid_b && !out_rdy;
    held_b  = {out_last_b, out_data_b};
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_rdy = rdy_pat[phase % 4];
    phase++;
  end

  task automatic applyStimulus(input logic [110:0] b);
    logic [127:0] junk;
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    hdr_bundle = b;
    hdr_valid  = 1'b1;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      if (hdr_rdy && hdr_rdy_b) acc = 1'b1;
    end
    @(posedge clk); #1;
    hdr_valid  = 1'b0;
    junk       = {$urandom, $urandom, $urandom, $urandom};
    hdr_bundle = junk[110:0];
    if (acc) cnt_exp = cnt_exp + 16'd1;
    else checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (sbq_a.size() == 0 && sbq_b.size() == 0 && !busy && !busy_b) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [110:0] b2b [0:2];
    int pulses;
    logic [127:0] junk;

    vecs[0] = '{5'd17, 2'b10, 49'h1_2345_6789_ABCD, 11'h123, 11'h7FF, 19'h5_A5A5, 1'b1,
                3'd0, 5'd0, 5'b00000, 4'b1111, 16'hE8C0, 16'h07FF, 9};
    vecs[1] = '{5'd17, 2'b10, 49'h1_2345_6789_ABCD, 11'h123, 11'h7FF, 19'h5_A5A5, 1'b0,
                3'd0, 5'd0, 5'b00000, 4'b1111, 16'hE8C0, 16'h07FF, 7};
    vecs[2] = '{5'd31, 2'b11, 49'h0, 11'h000, 11'h000, 19'h7_FFFF, 1'b1,
                3'b101, 5'h15, 5'b11111, 4'b1001, 16'hEFFF, 16'h0000, 9};
    vecs[3] = '{5'd0, 2'b01, 49'h0_0000_DEAD_BEEF, 11'h2AA, 11'h555, 19'h3_1234, 1'b0,
                3'd6, 5'h03, 5'b10100, 4'b1001, 16'hE034, 16'h0555, 7};
    vecs[4] = '{5'd9, 2'b00, 49'h0_F0F0_1234_5678, 11'h400, 11'h001, 19'h2_0001, 1'b1,
                3'd2, 5'h0A, 5'b00011, 4'b1101, 16'hE483, 16'h0001, 9};

    $display("[TB] reset with hdr_valid held high");
    rst_n      = 1'b0;
    hdr_valid  = 1'b1;
    hdr_bundle = pack_vec(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hdr_rdy", {31'd0, hdr_rdy}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
    checkOutput("rst_out_data", {16'd0, out_data}, 32'd0);
    checkOutput("rst_hdr_cnt", {16'd0, hdr_cnt}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_hdr_rdy", {31'd0, hdr_rdy}, 32'd1);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    cnt_exp   = 16'd1;
    wait_drain();
    checkOutput("release_cnt_a", {16'd0, hdr_cnt}, {16'd0, cnt_exp});
    checkOutput("release_cnt_b", {16'd0, hdr_cnt_b}, {16'd0, cnt_exp});

    $display("[TB] reference header word by word");
    applyStimulus(pack_vec(vecs[0]));
    wait_drain();
    checkOutput("ref_w0", {16'd0, cap[0]}, 32'hE8C0);
    checkOutput("ref_w1", {16'd0, cap[1]}, 32'h0081);
    checkOutput("ref_w2", {16'd0, cap[2]}, 32'h2345);
    checkOutput("ref_w3", {16'd0, cap[3]}, 32'h6789);
    checkOutput("ref_w4", {16'd0, cap[4]}, 32'hABCD);
    checkOutput("ref_w5", {16'd0, cap[5]}, 32'h0123);
    checkOutput("ref_w6", {16'd0, cap[6]}, 32'h07FF);
    checkOutput("ref_w7", {16'd0, cap[7]}, 32'h0005);
    checkOutput("ref_w8", {16'd0, cap[8]}, 32'hA5A5);

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++) begin
      rdy_pat = vecs[i].rdy;
      applyStimulus(pack_vec(vecs[i]));
      wait_drain();
      checkOutput($sformatf("vec%0d_len", i), cap_n, vecs[i].exp_len);
      checkOutput($sformatf("vec%0d_w0", i), {16'd0, cap[0]}, {16'd0, vecs[i].exp_w0});
      checkOutput($sformatf("vec%0d_w6", i), {16'd0, cap[6]}, {16'd0, vecs[i].exp_w6});
      checkOutput($sformatf("vec%0d_cnt_a", i), {16'd0, hdr_cnt}, {16'd0, cnt_exp});
      checkOutput($sformatf("vec%0d_cnt_b", i), {16'd0, hdr_cnt_b}, {16'd0, cnt_exp});
    end
    rdy_pat = 4'b1111;

    $display("[TB] back-to-back headers");
    b2b[0] = pack_vec(vecs[0]);
    b2b[1] = pack_vec(vecs[2]);
    b2b[2] = pack_vec(vecs[4]);
    pulses = 0;
    @(posedge clk); #1;
    hdr_bundle = b2b[0];
    hdr_valid  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bit acc;
      @(negedge clk);
      acc = hdr_valid && hdr_rdy;
      if (acc) pulses++;
      if (c == 29) checkOutput("b2b_busy_last_cycle", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      if (acc) begin
        if (pulses < 3) hdr_bundle = b2b[pulses];
        else begin
          hdr_valid  = 1'b0;
          junk       = {$urandom, $urandom, $urandom, $urandom};
          hdr_bundle = junk[110:0];
        end
      end
    end
    @(negedge clk);
    checkOutput("b2b_pulses", pulses, 3);
    checkOutput("b2b_idle_after_30", {31'd0, busy}, 32'd0);
    cnt_exp = cnt_exp + 16'd3;
    wait_drain();
    checkOutput("b2b_cnt", {16'd0, hdr_cnt}, {16'd0, cnt_exp});

    $display("[TB] header counter wrap");
    @(posedge clk); #1;
    force dut.hdr_cnt_q = 16'hFFFF;
    force dut_b.hdr_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.hdr_cnt_q;
    release dut_b.hdr_cnt_q;
    cnt_exp = 16'hFFFF;
    @(negedge clk);
    checkOutput("wrap_preload", {16'd0, hdr_cnt}, 32'hFFFF);
    applyStimulus(pack_vec(vecs[3]));
    wait_drain();
    checkOutput("wrap_cnt_a", {16'd0, hdr_cnt}, 32'h0000);
    checkOutput("wrap_cnt_b", {16'd0, hdr_cnt_b}, 32'h0000);

    $display("[TB] reset in the middle of a header");
    applyStimulus(pack_vec(vecs[0]));
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_w4", {16'd0, out_data}, 32'hABCD);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_cnt", {16'd0, hdr_cnt}, 32'd0);
    rst_n   = 1'b1;
    cnt_exp = 16'd0;
    applyStimulus(pack_vec(vecs[2]));
    wait_drain();
    checkOutput("after_rst_len", cap_n, 9);
    checkOutput("after_rst_w0", {16'd0, cap[0]}, 32'hEFFF);
    checkOutput("after_rst_cnt", {16'd0, hdr_cnt}, {16'd0, cnt_exp});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
